imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch sequencer and port arbiter for the 64 KB instruction memory (combinational read, word-indexed by addr[15:2]).
//  Owns the PC and prefetches into a small buffer, handing instructions to decode over a valid/ready handshake.
//  Shares the memory port with a program-load path. Sits between the instruction memory and the decode stage.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC after reset and after a load session ends
//  ADDR_W     16             byte-address bits decoded by instruction memory; PC wraps modulo 2**ADDR_W
//  BUF_DEPTH  2              prefetch buffer entries (power of 2, >=2)
// PORTS
//  clk            in   1   single clock, rising edge
//  reset          in   1   synchronous, active-high
//  imem_addr      out  32  byte address to instruction memory: {0, addr[ADDR_W-1:2], 2'b00}
//  imem_rdata     in   32  instruction read combinationally at imem_addr
//  imem_we        out  1   write strobe to instruction memory (load path)
//  imem_wdata     out  32  write data (load path)
//  load_en        in   1   level: loader owns the memory port this cycle
//  load_addr      in   32  loader byte address (word aligned)
//  load_data      in   32  loader write data
//  redirect_valid in   1   branch/jump redirect, one-cycle pulse
//  redirect_pc    in   32  redirect target
//  inst_valid     out  1   buffer head valid
//  inst_ready     in   1   decode accepts head
//  inst_data      out  32  head instruction
//  inst_pc        out  32  PC of head instruction
//  fault          out  1   sticky misaligned-redirect flag
// BEHAVIOUR
//  Reset: state=RUN, pc=RESET_PC, buffer empty; inst_valid=0, inst_data=0, inst_pc=0, fault=0, imem_we=0.
//  FSM states: RUN, LOAD, FAULT. Outputs inst_* are driven from buffer head (registered storage).
//  RUN: imem_addr=pc. Enqueue {pc, imem_rdata} when buffer not full OR a pop occurs in the same cycle; then pc<=pc+4 (wraps).
//  Pop when inst_valid && inst_ready. Latency: reset released in cycle 0 -> inst_valid=1 in cycle 1 with inst_pc=RESET_PC.
//  Full buffer and no pop: no enqueue, pc holds, imem_addr stays pc.
//  Redirect (RUN, redirect_pc[1:0]==0): pop in that cycle still completes; all remaining entries are flushed.
//   No enqueue; pc<=redirect_pc. The first redirected instruction is valid the next cycle.
//  Redirect with redirect_pc[1:0]!=0: flush, enter FAULT, fault<=1; pc unchanged.
//  FAULT: inst_valid=0, no fetch, redirects ignored. Exit only via reset or load_en.
//  load_en=1 (any state) has priority over redirect. Next state LOAD; buffer flushed the same cycle; no enqueue.
//   imem_addr=load_addr, imem_wdata=load_data, imem_we=1 combinationally in every cycle load_en=1.
//  LOAD: inst_valid=0. On the first cycle with load_en=0, state<=RUN, pc<=RESET_PC, fault<=0; fetch resumes the following cycle.
//  imem_we=0 whenever load_en=0. reset overrides everything, including mid-load or mid-redirect.
//  No enqueue in a redirect or load cycle, so the buffer never holds a stale-path entry.
// STRUCTURE
//  Shared package mips_pkg:
//   - INSTR_W=32, RESET_PC default, fetch state encoding (RUN/LOAD/FAULT).
//   - NOP=32'h0000_0000, the value driven on inst_data when empty.
//  Sub-module fetch_buf: BUF_DEPTH x 64-bit sync FIFO.
//   - Ports: push, pop, flush (flush wins over push), full, empty, head.
//   - Ptr wrap via extra MSB; a simultaneous push and pop on a full buffer is legal.
//  Top level holds the FSM, the PC register and the memory-port mux.
// TESTING
//  1 Reset, inst_ready=1, mem[i]=i -> inst_pc 0,4,8,... on consecutive cycles; inst_data 0,1,2; inst_valid from cycle 1.
//  2 inst_ready=0 for 5 cycles -> 2 entries buffered, pc held at 8; on release pcs 0,4,8 with no gap or duplicate.
//  3 Redirect to 0x100 while head pc=0x8 is popped -> 0x8 accepted, 0xC dropped; next inst_pc=0x100.
//  4 redirect_pc=0x102 -> fault=1, inst_valid=0 thereafter; redirect to 0x200 ignored; reset clears fault.
//  5 Load session: load_en 3 cycles, addr 0/4/8, data A/B/C, mid-fetch -> imem_we=1 for 3 cycles, buffer flushed;
//    then inst_pc=0 with data=A, 4 with B.
//  6 pc=0xFFFC (ADDR_W=16), ready=1 -> next inst_pc=0x0000 (wrap). Assert reset during load -> state RUN, imem_we=0 next cycle.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package imem_fetch_ctrl_pkg;

  localparam int          INSTR_W      = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP   = '0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] inst;
  } fetch_entry_t;

  // Reduce a byte address to the window decoded by instruction memory.
  function automatic logic [31:0] wrap_addr(input logic [31:0] a, input int unsigned aw);
    logic [31:0] m;
    m = (aw >= 32) ? 32'hFFFF_FFFF : ((32'h1 << aw) - 32'h1);
    return a & m;
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Memory port, loader, redirect and decode handshake bundle of the fetch controller.
interface imem_fetch_ctrl_if;
  import imem_fetch_ctrl_pkg::*;

  logic [31:0]        imem_addr;
  logic [31:0]        imem_rdata;
  logic               imem_we;
  logic [31:0]        imem_wdata;
  logic               load_en;
  logic [31:0]        load_addr;
  logic [31:0]        load_data;
  logic               redirect_valid;
  logic [31:0]        redirect_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic [INSTR_W-1:0] inst_data;
  logic [31:0]        inst_pc;
  logic               fault;

  modport master (
    output imem_addr, imem_we, imem_wdata, inst_valid, inst_data, inst_pc, fault,
    input  imem_rdata, load_en, load_addr, load_data, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_addr, imem_we, imem_wdata, inst_valid, inst_data, inst_pc, fault,
    output imem_rdata, load_en, load_addr, load_data, redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/imem_fetch_ctrl_fetch_buf.sv
// Small synchronous FIFO holding prefetched {pc, instruction} entries.
module fetch_buf #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  // Push into a full buffer is fine when the head leaves in the same cycle.
  assign do_push = push && (!full || pop) && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, prefetches into fetch_buf and arbitrates the
// instruction memory port between fetch and the program loader.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter int          ADDR_W    = 16,
  parameter int          BUF_DEPTH = 2
) (
  input logic               clk,
  input logic               reset,
  imem_fetch_ctrl_if.master bus
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic         fault_q, fault_n;
  logic         push, pop, flush, full, empty;
  fetch_entry_t wr_entry, head;

  fetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     ($bits(fetch_entry_t))
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (wr_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign bus.inst_valid = (state == RUN) && !empty;
  assign bus.inst_data  = bus.inst_valid ? head.inst : NOP;
  assign bus.inst_pc    = bus.inst_valid ? head.pc : 32'h0;
  assign bus.fault      = fault_q;
  assign bus.imem_we    = bus.load_en;
  assign bus.imem_wdata = bus.load_data;

  assign pop      = bus.inst_valid && bus.inst_ready;
  assign wr_entry = '{pc: pc, inst: bus.imem_rdata};

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pc      <= wrap_addr(RESET_PC, ADDR_W);
      fault_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      fault_q <= fault_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    fault_n       = fault_q;
    push          = 1'b0;
    flush         = 1'b0;
    bus.imem_addr = wrap_addr(pc, ADDR_W) & ~32'h3;
    if (bus.load_en) begin
      // Loader wins the port in any state; prefetched entries would be stale.
      state_n       = LOAD;
      flush         = 1'b1;
      bus.imem_addr = wrap_addr(bus.load_addr, ADDR_W) & ~32'h3;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.redirect_valid) begin
            flush = 1'b1;
            if (bus.redirect_pc[1:0] == 2'b00) begin
              pc_n = wrap_addr(bus.redirect_pc, ADDR_W);
            end else begin
              state_n = FAULT;
              fault_n = 1'b1;
            end
          end else if (!full || pop) begin
            push = 1'b1;
            pc_n = wrap_addr(pc + 32'd4, ADDR_W);
          end
        end
        LOAD: begin
          state_n = RUN;
          pc_n    = wrap_addr(RESET_PC, ADDR_W);
          fault_n = 1'b0;
        end
        FAULT: ;
        default: state_n = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized scoreboard bench for imem_fetch_ctrl against a queue-based reference model.
module tb_imem_fetch_ctrl;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if bus();

  imem_fetch_ctrl #(
    .RESET_PC  (32'h0000_0000),
    .ADDR_W    (16),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Instruction memory: untouched words read back as their own word index.
  bit [31:0] mem   [16384];
  bit        wflag [16384];
  logic [13:0] midx;
  assign midx = bus.imem_addr[15:2];
  assign bus.imem_rdata = wflag[midx] ? mem[midx] : {18'b0, midx};
  always @(posedge clk) begin
    if (bus.imem_we) begin
      mem[bus.imem_addr[15:2]]   <= bus.imem_wdata;
      wflag[bus.imem_addr[15:2]] <= 1'b1;
    end
  end

  // Reference model: mode 0 fetching, 1 loading, 2 faulted.
  int        m_mode;
  bit [31:0] m_pc;
  bit        m_fault;
  bit [63:0] m_q[$];
  bit [31:0] ref_mem [16384];

  bit [63:0] sb[$];
  bit        checking = 1'b0;
  bit        exp_valid, exp_we, chk_addr;
  bit [63:0] exp_head;
  bit        exp_fault;
  bit [31:0] exp_addr, exp_wdata;
  int        n_chk = 0;
  int        n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit rdy, input bit rv, input bit [31:0] rpc,
                      input bit ld, input bit [31:0] la, input bit [31:0] ldd);
    @(posedge clk);
    #1;
    reset              = rst;
    bus.inst_ready     = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.load_en        = ld;
    bus.load_addr      = la;
    bus.load_data      = ldd;
    exp_valid = (m_mode == 0) && (m_q.size() > 0);
    exp_head  = exp_valid ? m_q[0] : 64'h0;
    exp_fault = m_fault;
    exp_we    = ld;
    exp_wdata = ldd;
    chk_addr  = ld || (m_mode == 0);
    exp_addr  = ld ? (la & 32'hFFFC) : m_pc;
    if (exp_valid && rdy) sb.push_back(m_q[0]);
    checking = 1'b1;
    if (ld) ref_mem[la[15:2]] = ldd;
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_fault = 1'b0; m_q.delete();
    end else if (ld) begin
      m_mode = 1; m_q.delete();
    end else if (m_mode == 0) begin
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (rv) begin
        m_q.delete();
        if (rpc % 4 == 0) m_pc = rpc % 65536;
        else begin m_mode = 2; m_fault = 1'b1; end
      end else if (m_q.size() < DEPTH) begin
        m_q.push_back({m_pc, ref_mem[m_pc / 4]});
        m_pc = (m_pc + 4) % 65536;
      end
    end else if (m_mode == 1) begin
      m_mode = 0; m_pc = 32'h0; m_fault = 1'b0;
    end
  endtask

  task automatic run(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, rdy, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("inst_valid", {31'b0, bus.inst_valid}, {31'b0, exp_valid});
      chk("fault", {31'b0, bus.fault}, {31'b0, exp_fault});
      chk("imem_we", {31'b0, bus.imem_we}, {31'b0, exp_we});
      if (exp_we) chk("imem_wdata", bus.imem_wdata, exp_wdata);
      if (chk_addr) chk("imem_addr", bus.imem_addr, exp_addr);
      chk("inst_pc", bus.inst_pc, exp_head[63:32]);
      chk("inst_data", bus.inst_data, exp_head[31:0]);
      if (bus.inst_valid && bus.inst_ready) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_accept: got pc %h with nothing expected", bus.inst_pc);
        end else begin
          bit [63:0] e;
          e = sb.pop_front();
          chk("accept_pc", bus.inst_pc, e[63:32]);
          chk("accept_data", bus.inst_data, e[31:0]);
        end
      end
      chk("missing_accept", sb.size(), 0);
      sb.delete();
    end
  end

  initial begin
    int burst;
    bit [31:0] la;
    for (int i = 0; i < 16384; i++) ref_mem[i] = i;
    m_mode = 0; m_pc = 0; m_fault = 0;
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
    repeat (3) @(posedge clk);

    // Streaming from reset, then back-pressure with buffer full
    run(5, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    run(5, 0);
    run(4, 1);
    // Redirect while 0x8 is being accepted
    step(1, 0, 0, 0, 0, 0, 0);
    run(3, 0);
    run(2, 1);
    step(0, 1, 1, 32'h100, 0, 0, 0);
    run(3, 1);
    // Misaligned redirect, ignored redirect while faulted, reset recovery
    step(0, 1, 1, 32'h102, 0, 0, 0);
    run(2, 1);
    step(0, 1, 1, 32'h200, 0, 0, 0);
    run(2, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    run(3, 1);
    // Load session mid-fetch
    step(0, 1, 0, 0, 1, 32'h0, 32'hAAAA_0001);
    step(0, 1, 0, 0, 1, 32'h4, 32'hBBBB_0002);
    step(0, 1, 0, 0, 1, 32'h8, 32'hCCCC_0003);
    run(5, 1);
    // PC wrap at the top of the window
    step(0, 1, 1, 32'hFFF8, 0, 0, 0);
    run(5, 1);
    // Reset during a load
    step(0, 1, 0, 0, 1, 32'h40, 32'h1234_5678);
    step(1, 1, 0, 0, 1, 32'h44, 32'h9ABC_DEF0);
    run(3, 1);
    // Load session exiting from FAULT
    step(0, 1, 1, 32'h3, 0, 0, 0);
    run(2, 1);
    step(0, 1, 0, 0, 1, 32'h10, 32'h5555_AAAA);
    run(4, 1);

    burst = 0;
    la = 0;
    for (int c = 0; c < 4000; c++) begin
      if (burst == 0 && $urandom_range(0, 99) == 0) begin
        burst = $urandom_range(1, 4);
        la = $urandom() & 32'hFFFC;
      end
      if (burst > 0) begin
        step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom() & 32'hFFFC, 1, la, $urandom());
        la = (la + 4) & 32'hFFFC;
        burst--;
      end else if ($urandom_range(0, 499) == 0) begin
        step(1, $urandom_range(0, 1), 0, 0, 0, 0, 0);
      end else if ($urandom_range(0, 15) == 0) begin
        step(0, $urandom_range(0, 3) != 0, 1,
             ($urandom_range(0, 30) == 0) ? ($urandom() | 32'h1) : ($urandom() & 32'hFFFC), 0, 0, 0);
      end else begin
        step(0, $urandom_range(0, 9) < 7, 0, 0, 0, 0, 0);
      end
    end

    @(posedge clk);
    #1;
    checking = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
